data_bus_ctrl: RTL and testbench

Memory-side stage directly downstream of the single-cycle processor core. Consumes the core's data-access outputs (address, write strobe, write data), decodes them into a word-addressed data RAM and a small set of memory-mapped registers, and returns ReadData combinationally in the same cycle. Also provides a free-running cycle counter and a byte output FIFO with a valid/ready drain port for a downstream consumer such as a UART or display driver.

---
 rtl/data_bus_ctrl.sv | 119 +++++++++++
 tb/tb_data_bus_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_bus_ctrl : data RAM, cycle counter and byte output FIFO behind core bus
// Revision 1.0
// ---------------------------------------------------------------------------
module data_bus_ctrl #(
   parameter int RAM_WORDS  = 64,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [29:0] CYCLE_WADDR  = 30'h400;
   localparam logic [29:0] FDATA_WADDR  = 30'h401;
   localparam logic [29:0] STATUS_WADDR = 30'h402;

   logic [31:0]   ram [RAM_WORDS];
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [31:0]   cycle_count;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;

   logic [29:0]   waddr;
   logic [AW-1:0] ram_idx;
   logic          ram_hit;
   logic          fdata_hit;
   logic          status_hit;
   logic          push_req;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [7:0]    status_count;
   logic          unused_addr_bits;

   // Byte offset is ignored: every access is a full word.
   assign waddr            = ALUResult[31:2];
   assign unused_addr_bits = ^ALUResult[1:0];
   assign ram_idx          = waddr[AW-1:0];
   assign ram_hit          = (waddr[29:AW] == '0);
   assign fdata_hit        = (waddr == FDATA_WADDR);
   assign status_hit       = (waddr == STATUS_WADDR);

   assign full      = (count == CW'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign push_req  = MemWrite && fdata_hit;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push      = push_req && (!full || pop);
   assign pop       = out_valid && out_ready;
   assign out_valid = !empty;
   assign out_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

   assign status_count = 8'(count);

   always_comb begin
      ReadData = 32'h0000_0000;
      if (ram_hit) begin
         ReadData = ram[ram_idx];
      end else if (waddr == CYCLE_WADDR) begin
         ReadData = cycle_count;
      end else if (status_hit) begin
         ReadData = {16'h0000, status_count, 5'b00000, overflow, full, empty};
      end
   end

   // Storage arrays carry no reset so RAM contents survive a reset.
   always_ff @(posedge clk) begin
      if (MemWrite && ram_hit) begin
         ram[ram_idx] <= WriteData;
      end
      if (push) begin
         fifo_mem[wr_ptr] <= WriteData[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_count <= 32'h0000_0000;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         overflow    <= 1'b0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
         if (MemWrite && status_hit) begin
            overflow <= 1'b0;
         end else if (push_req && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_data_bus_ctrl : directed self-checking bench for data_bus_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_data_bus_ctrl;

   localparam logic [31:0] A_CYCLE  = 32'h0000_1000;
   localparam logic [31:0] A_FDATA  = 32'h0000_1004;
   localparam logic [31:0] A_STATUS = 32'h0000_1008;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemWrite = 1'b0;
   logic [31:0] ALUResult = 32'h0;
   logic [31:0] WriteData = 32'h0;
   logic [31:0] ReadData;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;

   int assertions = 0;
   int failures   = 0;

   always #5 clk = ~clk;

   data_bus_ctrl #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rd(input logic [31:0] a);
      MemWrite  = 1'b0;
      ALUResult = a;
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      MemWrite  = 1'b1;
      ALUResult = a;
      WriteData = d;
      step();
      MemWrite  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      rd(A_STATUS);
      assertions++;
      if (ReadData !== 32'h0000_0001) begin
         failures++;
         $display("FAIL reset_status: got %h expected %h", ReadData, 32'h1);
      end
      assertions++;
      if ({out_valid, out_data} !== 9'h000) begin
         failures++;
         $display("FAIL reset_out: got valid=%b data=%h expected 0/00", out_valid, out_data);
      end
      for (int i = 0; i < 4; i++) begin
         rd(A_CYCLE);
         assertions++;
         if (ReadData !== 32'(i)) begin
            failures++;
            $display("FAIL cycle_count[%0d]: got %h expected %h", i, ReadData, 32'(i));
         end
         step();
      end
   endtask

   task automatic test_cycle_wrap();
      logic [31:0] exp_vals [4];
      exp_vals[0] = 32'hFFFF_FFFE;
      exp_vals[1] = 32'hFFFF_FFFF;
      exp_vals[2] = 32'h0000_0000;
      exp_vals[3] = 32'h0000_0001;
      dut.cycle_count = 32'hFFFF_FFFE;
      for (int i = 0; i < 4; i++) begin
         rd(A_CYCLE);
         assertions++;
         if (ReadData !== exp_vals[i]) begin
            failures++;
            $display("FAIL cycle_wrap[%0d]: got %h expected %h", i, ReadData, exp_vals[i]);
         end
         step();
      end
   endtask

   task automatic test_ram();
      wr(32'h0000_0010, 32'hDEAD_BEEF);
      wr(32'h0000_0014, 32'h1234_5678);
      rd(32'h0000_0010);
      assertions++;
      if (ReadData !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL ram_rd_10: got %h expected %h", ReadData, 32'hDEAD_BEEF);
      end
      rd(32'h0000_0014);
      assertions++;
      if (ReadData !== 32'h1234_5678) begin
         failures++;
         $display("FAIL ram_rd_14: got %h expected %h", ReadData, 32'h1234_5678);
      end
      rd(32'h0000_0013);
      assertions++;
      if (ReadData !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL ram_alias_13: got %h expected %h", ReadData, 32'hDEAD_BEEF);
      end
      step();
      // write in progress: read sees the old word
      MemWrite  = 1'b1;
      ALUResult = 32'h0000_0010;
      WriteData = 32'hCAFE_F00D;
      #1;
      assertions++;
      if (ReadData !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL ram_same_cycle: got %h expected %h", ReadData, 32'hDEAD_BEEF);
      end
      step();
      MemWrite = 1'b0;
      rd(32'h0000_0010);
      assertions++;
      if (ReadData !== 32'hCAFE_F00D) begin
         failures++;
         $display("FAIL ram_new_data: got %h expected %h", ReadData, 32'hCAFE_F00D);
      end
      step();
      wr(32'h0000_0000, 32'h1111_0000);
      wr(32'h0000_0020, 32'hA5A5_0F0F);
      wr(32'h0000_0800, 32'h5555_5555);
      rd(32'h0000_0000);
      assertions++;
      if (ReadData !== 32'h1111_0000) begin
         failures++;
         $display("FAIL ram_unmapped_wr: got %h expected %h", ReadData, 32'h1111_0000);
      end
      rd(32'h0000_0800);
      assertions++;
      if (ReadData !== 32'h0) begin
         failures++;
         $display("FAIL unmapped_rd_800: got %h expected %h", ReadData, 32'h0);
      end
      rd(32'h0000_0100);
      assertions++;
      if (ReadData !== 32'h0) begin
         failures++;
         $display("FAIL unmapped_rd_100: got %h expected %h", ReadData, 32'h0);
      end
      step();
   endtask

   task automatic test_fifo_fill();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wr(A_FDATA, 32'h41 + 32'(i));
         assertions++;
         if ({out_valid, out_data} !== {1'b1, 8'h41}) begin
            failures++;
            $display("FAIL fill_head[%0d]: got valid=%b data=%h expected 1/41", i, out_valid, out_data);
         end
      end
      rd(A_STATUS);
      assertions++;
      if (ReadData !== 32'h0000_0802) begin
         failures++;
         $display("FAIL fill_status_full: got %h expected %h", ReadData, 32'h802);
      end
      wr(A_FDATA, 32'h49);
      rd(A_STATUS);
      assertions++;
      if (ReadData !== 32'h0000_0806) begin
         failures++;
         $display("FAIL fill_status_ovf: got %h expected %h", ReadData, 32'h806);
      end
      assertions++;
      if (out_data !== 8'h41) begin
         failures++;
         $display("FAIL fill_head_after_ovf: got %h expected %h", out_data, 8'h41);
      end
      rd(A_FDATA);
      assertions++;
      if (ReadData !== 32'h0) begin
         failures++;
         $display("FAIL fdata_read: got %h expected %h", ReadData, 32'h0);
      end
      wr(A_STATUS, 32'hFFFF_FFFF);
      rd(A_STATUS);
      assertions++;
      if (ReadData !== 32'h0000_0802) begin
         failures++;
         $display("FAIL ovf_clear: got %h expected %h", ReadData, 32'h802);
      end
      step();
   endtask

   task automatic test_drain();
      MemWrite  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         assertions++;
         if ({out_valid, out_data} !== {1'b1, 8'h41 + 8'(i)}) begin
            failures++;
            $display("FAIL drain[%0d]: got valid=%b data=%h expected 1/%h", i, out_valid, out_data, 8'h41 + 8'(i));
         end
         step();
      end
      #1;
      out_ready = 1'b0;
      assertions++;
      if ({out_valid, out_data} !== 9'h000) begin
         failures++;
         $display("FAIL drain_empty: got valid=%b data=%h expected 0/00", out_valid, out_data);
      end
      rd(A_STATUS);
      assertions++;
      if (ReadData !== 32'h0000_0001) begin
         failures++;
         $display("FAIL drain_status: got %h expected %h", ReadData, 32'h1);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wr(A_FDATA, 32'h61 + 32'(i));
      end
      MemWrite  = 1'b1;
      ALUResult = A_FDATA;
      WriteData = 32'h99;
      out_ready = 1'b1;
      step();
      MemWrite  = 1'b0;
      out_ready = 1'b0;
      rd(A_STATUS);
      assertions++;
      if (ReadData !== 32'h0000_0802) begin
         failures++;
         $display("FAIL full_pushpop_status: got %h expected %h", ReadData, 32'h802);
      end
      assertions++;
      if (out_data !== 8'h62) begin
         failures++;
         $display("FAIL full_pushpop_head: got %h expected %h", out_data, 8'h62);
      end
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_b = (i < 7) ? (8'h62 + 8'(i)) : 8'h99;
         #1;
         assertions++;
         if ({out_valid, out_data} !== {1'b1, exp_b}) begin
            failures++;
            $display("FAIL pushpop_drain[%0d]: got valid=%b data=%h expected 1/%h", i, out_valid, out_data, exp_b);
         end
         step();
      end
      #1;
      out_ready = 1'b0;
      assertions++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL pushpop_empty: got %b expected 0", out_valid);
      end
      step();
   endtask

   task automatic test_push_empty();
      MemWrite  = 1'b1;
      ALUResult = A_FDATA;
      WriteData = 32'h5A;
      #1;
      assertions++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL push_empty_same_cycle: got %b expected 0", out_valid);
      end
      step();
      MemWrite = 1'b0;
      #1;
      assertions++;
      if ({out_valid, out_data} !== {1'b1, 8'h5A}) begin
         failures++;
         $display("FAIL push_empty_next: got valid=%b data=%h expected 1/5a", out_valid, out_data);
      end
      step();
   endtask

   task automatic test_reset_mid_drain();
      for (int i = 0; i < 7; i++) begin
         wr(A_FDATA, 32'h70 + 32'(i));
      end
      wr(A_FDATA, 32'h7F);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
      end
      out_ready = 1'b0;
      rd(A_STATUS);
      assertions++;
      if (ReadData !== 32'h0000_0304) begin
         failures++;
         $display("FAIL partial_status: got %h expected %h", ReadData, 32'h304);
      end
      assertions++;
      if (out_data !== 8'h74) begin
         failures++;
         $display("FAIL partial_head: got %h expected %h", out_data, 8'h74);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      rd(A_STATUS);
      assertions++;
      if (ReadData !== 32'h0000_0001) begin
         failures++;
         $display("FAIL rst_mid_status: got %h expected %h", ReadData, 32'h1);
      end
      assertions++;
      if ({out_valid, out_data} !== 9'h000) begin
         failures++;
         $display("FAIL rst_mid_out: got valid=%b data=%h expected 0/00", out_valid, out_data);
      end
      rd(A_CYCLE);
      assertions++;
      if (ReadData !== 32'h0) begin
         failures++;
         $display("FAIL rst_mid_cycle: got %h expected %h", ReadData, 32'h0);
      end
      rd(32'h0000_0020);
      assertions++;
      if (ReadData !== 32'hA5A5_0F0F) begin
         failures++;
         $display("FAIL rst_ram_hold: got %h expected %h", ReadData, 32'hA5A5_0F0F);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_cycle_wrap();
      test_ram();
      test_fifo_fill();
      test_drain();
      test_back_to_back();
      test_push_empty();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
`default_nettype wire
